// File: rtl/ysyx_22040895_lsu.sv
// ysyx_22040895_lsu: single-beat valid/ready load/store unit with aligned, extended load return.
// Optional YSYX_22040895_MISALIGN_CHK_EN flags misaligned accesses instead of force-aligning them.
module ysyx_22040895_lsu #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic              we_i,
    input  logic [1:0]        munit_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              misalign_o,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [7:0]        mem_wstrb_o,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t            state, state_nxt;
    logic              we_q, uns_q, mis;
    logic [1:0]        munit_q;
    logic [ADDR_W-1:0] addr_q, addr_eff;
    logic [DATA_W-1:0] wdata_q, tmp, load_ext;
    logic [2:0]        lo_mask;
    logic [7:0]        strb;
    assign lo_mask = 3'((4'd1 << munit_i) - 4'd1);
`ifdef YSYX_22040895_MISALIGN_CHK_EN
    logic mis_q;
    assign mis      = |(addr_i[2:0] & lo_mask);
    assign addr_eff = addr_i;
`else
    assign mis      = 1'b0;
    assign addr_eff = {addr_i[ADDR_W-1:3], addr_i[2:0] & ~lo_mask};
`endif
    assign tmp      = mem_rdata_i >> {addr_q[2:0], 3'b000};
    assign load_ext = munit_q == 2'd0 ? {{(DATA_W-8){~uns_q & tmp[7]}}, tmp[7:0]} :
                      munit_q == 2'd1 ? {{(DATA_W-16){~uns_q & tmp[15]}}, tmp[15:0]} :
                      munit_q == 2'd2 ? {{(DATA_W-32){~uns_q & tmp[31]}}, tmp[31:0]} : tmp;
    assign strb     = munit_q == 2'd0 ? 8'h01 : munit_q == 2'd1 ? 8'h03 :
                      munit_q == 2'd2 ? 8'h0F : 8'hFF;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            munit_q <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_o <= '0;
`ifdef YSYX_22040895_MISALIGN_CHK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid_i) begin
                we_q    <= we_i;
                uns_q   <= unsigned_i;
                munit_q <= munit_i;
                addr_q  <= addr_eff;
                wdata_q <= wdata_i;
`ifdef YSYX_22040895_MISALIGN_CHK_EN
                mis_q   <= mis;
`endif
            end
            if (state == WAIT && mem_rvalid_i)
                rdata_o <= load_ext;
        end
    end
    // Bus outputs derive from latched command only, so they stay stable until accepted.
    always_comb begin
        state_nxt   = state;
        stall_o     = 1'b0;
        done_o      = 1'b0;
        mem_valid_o = 1'b0;
        mem_we_o    = 1'b0;
        mem_wstrb_o = 8'h00;
        mem_addr_o  = {addr_q[ADDR_W-1:3], 3'b000};
        mem_wdata_o = wdata_q << {addr_q[2:0], 3'b000};
        unique case (state)
            IDLE: begin
                stall_o = req_valid_i;
                if (req_valid_i) state_nxt = mis ? DONE : REQ;
            end
            REQ: begin
                stall_o     = 1'b1;
                mem_valid_o = 1'b1;
                mem_we_o    = we_q;
                mem_wstrb_o = we_q ? strb << addr_q[2:0] : 8'h00;
                if (mem_ready_i) state_nxt = we_q ? DONE : WAIT;
            end
            WAIT: begin
                stall_o = 1'b1;
                if (mem_rvalid_i) state_nxt = DONE;
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
`ifdef YSYX_22040895_MISALIGN_CHK_EN
    assign misalign_o = (state == DONE) & mis_q;
`else
    assign misalign_o = 1'b0;
`endif
endmodule

// File: tb/tb_ysyx_22040895_lsu.sv
// tb_ysyx_22040895_lsu: randomized self-checking bench with a byte-level reference model and bus responder.
module tb_ysyx_22040895_lsu;
    logic        clk = 1'b0, rst = 1'b0;
    logic        req_valid_i = 1'b0, we_i = 1'b0, unsigned_i = 1'b0;
    logic [1:0]  munit_i = 2'd0;
    logic [63:0] addr_i = '0, wdata_i = '0;
    logic        stall_o, done_o, misalign_o, mem_valid_o, mem_we_o;
    logic [63:0] rdata_o, mem_addr_o, mem_wdata_o;
    logic [7:0]  mem_wstrb_o;
    logic        mem_ready_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [63:0] mem_rdata_i = '0;
    logic [63:0] prev_rdata = '0;
    int          n_chk = 0, n_fail = 0;

    ysyx_22040895_lsu dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .we_i(we_i), .munit_i(munit_i),
        .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o),
        .done_o(done_o), .rdata_o(rdata_o), .misalign_o(misalign_o), .mem_valid_o(mem_valid_o),
        .mem_ready_i(mem_ready_i), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one command and plays the bus; rd = ready delay, rv = rvalid delay after handshake.
    task automatic run_op(input logic we, input logic [1:0] mu, input logic uns, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [63:0] rbus, input int rd, input int rv);
        int          size, off, done_at;
        logic        mis, exp_valid;
        logic [63:0] sz, ea, exp_addr, exp_wdata, v;
        logic [7:0]  exp_strb;
        size = 1 << mu;
        sz   = 64'(size);
`ifdef YSYX_22040895_MISALIGN_CHK_EN
        mis = (addr % sz) != 0;
        ea  = addr;
`else
        mis = 1'b0;
        ea  = addr - (addr % sz);
`endif
        off      = int'(ea % 64'd8);
        exp_addr = ea - 64'(off);
        exp_strb = '0;
        v        = '0;
        for (int i = 0; i < size; i++) begin
            if (we) exp_strb[off+i] = 1'b1;
            v[8*i +: 8] = rbus[8*(off+i) +: 8];
        end
        if (!uns && size < 8 && v[8*size-1])
            for (int i = 8*size; i < 64; i++) v[i] = 1'b1;
        exp_wdata = wdata << (8*off);
        if (!mis && !we) prev_rdata = v;
        done_at = mis ? 1 : we ? 2 + rd : 3 + rd + rv;
        req_valid_i = 1'b1; we_i = we; munit_i = mu; unsigned_i = uns; addr_i = addr; wdata_i = wdata;
        mem_ready_i = 1'b0; mem_rvalid_i = 1'b0;
        #1;
        check("stall_c0", stall_o, 1);
        check("done_gap", done_o, 0);
        check("valid_c0", mem_valid_o, 0);
        @(posedge clk); #1;
        for (int c = 1; c <= done_at; c++) begin
            mem_ready_i  = !mis && c == 1 + rd;
            if (!mis && !we && c == 2 + rd + rv) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = rbus;
            end else begin
                mem_rvalid_i = (c <= rd || c == done_at) ? 1'($urandom % 2) : 1'b0;
                mem_rdata_i  = {$urandom, $urandom};
            end
            #1;
            exp_valid = !mis && c <= 1 + rd;
            check("stall", stall_o, 64'(c < done_at));
            check("done", done_o, 64'(c == done_at));
            check("mem_valid", mem_valid_o, 64'(exp_valid));
            if (exp_valid) begin
                check("mem_addr", mem_addr_o, exp_addr);
                check("mem_we", mem_we_o, 64'(we));
                check("mem_wstrb", mem_wstrb_o, 64'(exp_strb));
                if (we) check("mem_wdata", mem_wdata_o, exp_wdata);
            end
            if (c == done_at) begin
                check("misalign", misalign_o, 64'(mis));
                check("rdata", rdata_o, prev_rdata);
            end
            @(posedge clk); #1;
        end
        req_valid_i = 1'b0; mem_ready_i = 1'b0; mem_rvalid_i = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", mem_valid_o, 0);
        check("rst_we", mem_we_o, 0);
        check("rst_strb", mem_wstrb_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_wdata", mem_wdata_o, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_done", done_o, 0);
        check("rst_mis", misalign_o, 0);
        check("rst_stall", stall_o, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        run_op(1'b1, 2'd2, 1'b0, 64'h8000_0004, 64'h1122_3344, 64'h0, 0, 0);
        run_op(1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'h0, 64'h0000_0000_80FF_0000, 0, 0);
        check("lb_signed", rdata_o, 64'hFFFF_FFFF_FFFF_FF80);
        run_op(1'b0, 2'd0, 1'b1, 64'h8000_0003, 64'h0, 64'h0000_0000_80FF_0000, 0, 0);
        check("lb_unsigned", rdata_o, 64'h80);
        run_op(1'b0, 2'd3, 1'b0, 64'h8000_0010, 64'h0, 64'hDEAD_BEEF_0123_4567, 3, 2);
        run_op(1'b0, 2'd1, 1'b0, 64'h8000_0001, 64'h0, 64'h1234_5678_9ABC_DEF0, 0, 0);
        run_op(1'b1, 2'd3, 1'b0, 64'h8000_0020, 64'hA5A5_5A5A_0F0F_F0F0, 64'h0, 1, 0);
        run_op(1'b0, 2'd2, 1'b1, 64'h8000_0024, 64'h0, 64'h8765_4321_0000_0000, 0, 1);
        // Abandon a load in the read-wait phase and feed it a late response.
        req_valid_i = 1'b1; we_i = 1'b0; munit_i = 2'd3; addr_i = 64'h8000_0040;
        @(posedge clk); #1;
        mem_ready_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0; mem_ready_i = 1'b0; rst = 1'b0;
        #1;
        check("mid_rst_valid", mem_valid_o, 0);
        check("mid_rst_stall", stall_o, 0);
        check("mid_rst_rdata", rdata_o, 0);
        prev_rdata = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'hFFFF_0000_FFFF_0000;
        #1;
        check("stale_done", done_o, 0);
        @(posedge clk); #1;
        mem_rvalid_i = 1'b0;
        #1;
        check("stale_done2", done_o, 0);
        check("stale_rdata", rdata_o, 0);
        check("stale_stall", stall_o, 0);
        for (int k = 0; k < 300; k++)
            run_op(1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2), {32'h0, $urandom},
                   {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
